// File: rtl/branch_offset_pipe.sv
// -----------------------------------------------------------------------------
// branch_offset_pipe
//
// Two-stage pipelined immediate extender and branch-target generator for the
// MIPS31 core. An IN_W immediate is extended to OUT_W according to a
// per-transaction mode, then added to PC+4. The extended value and the target
// leave through a valid/ready handshake.
//
// Modes (in_mode):
//   2'b00  sign-extend, then shift left by SHIFT
//   2'b01  zero-extend, then shift left by SHIFT
//   2'b10  immediate placed in the upper bits, low bits zero
//   2'b11  sign-extend, no shift
//
// Optional feature macro: BRANCH_OVF_CHECK_EN
//   defined   : out_ovf flags a target that left the 0..2^OUT_W-1 range
//               (mode 00/11 offset taken as signed, 01/10 as unsigned,
//               wrap of PC+4 included)
//   undefined : out_ovf is tied to 0
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous reset, active low
//   in_valid    request valid
//   in_ready    request accepted when in_valid && in_ready at a clock edge
//   in_mode     extension mode (see above)
//   in_imm      immediate field, IN_W bits
//   in_pc       PC of the instruction, OUT_W bits
//   out_valid   result valid
//   out_ready   consumer accepts when out_valid && out_ready at a clock edge
//   out_ext     extended/shifted immediate
//   out_target  in_pc + 4 + out_ext, modulo 2^OUT_W
//   out_ovf     target wrap flag (0 when BRANCH_OVF_CHECK_EN is undefined)
// -----------------------------------------------------------------------------
module branch_offset_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_mode,
    input  logic [IN_W-1:0]    in_imm,
    input  logic [OUT_W-1:0]   in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_ext,
    output logic [OUT_W-1:0]   out_target,
    output logic               out_ovf
);

    // Extension is done at full OUT_W width before shifting, so no immediate
    // bits are lost below OUT_W; the shift result is truncated to OUT_W.
    function automatic logic [OUT_W-1:0] extend_imm(input logic [1:0]      mode,
                                                    input logic [IN_W-1:0] imm);
        logic signed [OUT_W-1:0] sext;
        logic        [OUT_W-1:0] zext;
        logic        [OUT_W-1:0] res;
        sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
        zext = {{(OUT_W-IN_W){1'b0}}, imm};
        case (mode)
            2'b00:   res = OUT_W'(sext) << SHIFT;
            2'b01:   res = zext << SHIFT;
            2'b10:   res = {imm, {(OUT_W-IN_W){1'b0}}};
            default: res = OUT_W'(sext);
        endcase
        return res;
    endfunction

    logic               s1_adv;
    logic               s2_adv;
    logic [OUT_W:0]     pc4_full;

    logic               vld_p1;
    logic [OUT_W-1:0]   ext_p1;
    logic [OUT_W-1:0]   pc4_p1;

    logic               vld_p2;
    logic [OUT_W-1:0]   ext_p2;
    logic [OUT_W-1:0]   tgt_p2;

    // A stage may load when it is empty or its contents move on this edge.
    // in_ready depends only on stage state and out_ready, never on in_valid.
    assign s2_adv   = !vld_p2 || out_ready;
    assign s1_adv   = !vld_p1 || s2_adv;
    assign in_ready = s1_adv;

    // Carry out of PC+4 is kept for the optional overflow flag.
    assign pc4_full = {1'b0, in_pc} + (OUT_W+1)'(4);

    // ---- Stage S1: extend immediate, register with PC+4 ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            ext_p1 <= '0;
            pc4_p1 <= '0;
        end else if (s1_adv) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                ext_p1 <= extend_imm(in_mode, in_imm);
                pc4_p1 <= pc4_full[OUT_W-1:0];
            end
        end
    end

    // ---- Stage S2: target add, register as outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            ext_p2 <= '0;
            tgt_p2 <= '0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                ext_p2 <= ext_p1;
                tgt_p2 <= pc4_p1 + ext_p1;
            end
        end
    end

    assign out_valid  = vld_p2;
    assign out_ext    = ext_p2;
    assign out_target = tgt_p2;

`ifdef BRANCH_OVF_CHECK_EN
    // Mathematical pc+4+offset evaluated two bits wider than OUT_W: any
    // non-zero bit above OUT_W-1 means the true sum was negative or
    // reached 2^OUT_W.
    function automatic logic target_ovf(input logic             pc4_c,
                                        input logic [OUT_W-1:0] pc4,
                                        input logic [OUT_W-1:0] ext,
                                        input logic             ext_signed);
        logic signed [OUT_W+1:0] base_w;
        logic signed [OUT_W+1:0] ext_w;
        logic signed [OUT_W+1:0] sum_w;
        base_w = {1'b0, pc4_c, pc4};
        ext_w  = ext_signed ? {{2{ext[OUT_W-1]}}, ext} : {2'b00, ext};
        sum_w  = base_w + ext_w;
        return (sum_w[OUT_W+1:OUT_W] != 2'b00);
    endfunction

    logic pc4_c_p1;
    logic sgn_p1;
    logic ovf_p2;

    // ---- Stage S1: overflow side information ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc4_c_p1 <= 1'b0;
            sgn_p1   <= 1'b0;
        end else if (s1_adv && in_valid) begin
            pc4_c_p1 <= pc4_full[OUT_W];
            // Modes 00 and 11 carry a signed offset.
            sgn_p1   <= (in_mode[1] == in_mode[0]);
        end
    end

    // ---- Stage S2: overflow flag ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_p2 <= 1'b0;
        end else if (s2_adv && vld_p1) begin
            ovf_p2 <= target_ovf(pc4_c_p1, pc4_p1, ext_p1, sgn_p1);
        end
    end

    assign out_ovf = ovf_p2;
`else
    assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_branch_offset_pipe.sv
module tb_branch_offset_pipe;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] imm;
        logic [31:0] pc;
        logic [31:0] ext;
        logic [31:0] tgt;
        logic        ovf;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [15:0] in_imm;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ext;
    logic [31:0] out_target;
    logic        out_ovf;

    int   checks = 0;
    int   errors = 0;
    vec_t q[$];

    branch_offset_pipe #(.IN_W(16), .OUT_W(32), .SHIFT(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_imm     (in_imm),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ext    (out_ext),
        .out_target (out_target),
        .out_ovf    (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_ovf(input logic o);
`ifdef BRANCH_OVF_CHECK_EN
        return o;
`else
        return 1'b0;
`endif
    endfunction

    function automatic vec_t mk(input logic [1:0] m, input logic [15:0] i, input logic [31:0] p,
                                input logic [31:0] e, input logic [31:0] t, input logic o);
        vec_t v;
        v.mode = m; v.imm = i; v.pc = p; v.ext = e; v.tgt = t; v.ovf = o;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one request; returns after the accepting edge (+1) with the number
    // of cycles it was presented before acceptance.
    task automatic send(input vec_t v, output int tries);
        logic acc;
        acc      = 1'b0;
        tries    = 0;
        in_mode  = v.mode;
        in_imm   = v.imm;
        in_pc    = v.pc;
        in_valid = 1'b1;
        while (!acc && tries < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            tries++;
        end
        if (acc) q.push_back(v);
        else chk("send_timeout", 32'(acc), 32'd1);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
        #1;
    endtask

    // Monitor: compare the head of the scoreboard every cycle a result is
    // presented (so held outputs are rechecked under stall); pop on handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                chk("out_ext", out_ext, q[0].ext);
                chk("out_target", out_target, q[0].tgt);
                chk("out_ovf", 32'(out_ovf), 32'(exp_ovf(q[0].ovf)));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        vec_t dir[$];
        int   t;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 2'b00;
        in_imm    = '0;
        in_pc     = '0;
        out_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_ext", out_ext, 32'd0);
        chk("rst_out_target", out_target, 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: basic mode 00; output appears at the second edge counting the
        // accepting edge (two register stages)
        send(mk(2'b00, 16'h0004, 32'h0000_1000, 32'h0000_0010, 32'h0000_1014, 1'b0), t);
        chk("lat_after_accept", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_next_edge", 32'(out_valid), 32'd1);
        drain();

        // 2 and 5 plus extra boundary vectors, one at a time
        dir.push_back(mk(2'b00, 16'hFFFF, 32'h0000_1000, 32'hFFFF_FFFC, 32'h0000_1000, 1'b0));
        dir.push_back(mk(2'b01, 16'hFFFF, 32'h0000_1000, 32'h0003_FFFC, 32'h0004_1000, 1'b0));
        dir.push_back(mk(2'b10, 16'h1234, 32'h0000_1000, 32'h1234_0000, 32'h1234_1004, 1'b0));
        dir.push_back(mk(2'b11, 16'h8000, 32'h0000_1000, 32'hFFFF_8000, 32'hFFFF_9004, 1'b1));
        dir.push_back(mk(2'b00, 16'h0000, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b1));
        dir.push_back(mk(2'b01, 16'h8000, 32'h0000_0000, 32'h0002_0000, 32'h0002_0004, 1'b0));
        dir.push_back(mk(2'b10, 16'hFFFF, 32'hF000_0000, 32'hFFFF_0000, 32'hEFFF_0004, 1'b1));
        dir.push_back(mk(2'b11, 16'h7FFF, 32'h0000_0010, 32'h0000_7FFF, 32'h0000_8013, 1'b0));
        dir.push_back(mk(2'b00, 16'h8000, 32'h0001_0000, 32'hFFFE_0000, 32'hFFFF_0004, 1'b1));
        foreach (dir[i]) begin
            send(dir[i], t);
            drain();
        end

        // 3: eight back-to-back requests, in_ready must never drop
        for (int i = 0; i < 8; i++) begin
            send(mk(2'b00, 16'(i + 1), 32'h4000 + 32'(16 * i),
                    32'(4 * (i + 1)), 32'h4004 + 32'(20 * i) + 32'd4, 1'b0), t);
            chk("b2b_in_ready", 32'(t), 32'd1);
        end
        drain();

        // 4: stall out_ready for 5 cycles while streaming four requests
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(mk(2'b00, 16'h0010 + 16'(i), 32'h0000_8000,
                            32'h40 + 32'(4 * i), 32'h8044 + 32'(4 * i), 1'b0), t);
                end
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                chk("stall_out_valid", 32'(out_valid), 32'd1);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // 6: asynchronous reset with both stages full
        out_ready = 1'b0;
        send(mk(2'b00, 16'h0001, 32'h0000_2000, 32'h0000_0004, 32'h0000_2008, 1'b0), t);
        send(mk(2'b00, 16'h0002, 32'h0000_2000, 32'h0000_0008, 32'h0000_200C, 1'b0), t);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_ext", out_ext, 32'd0);
        chk("arst_out_target", out_target, 32'd0);
        #4 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        send(mk(2'b00, 16'h0004, 32'h0000_1000, 32'h0000_0010, 32'h0000_1014, 1'b0), t);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
